// File: rtl/pipa_sched_pkg.sv
// pipa_sched_pkg: shared types, slot constants and the saturating add used by the PIPA moding scheduler
package pipa_sched_pkg;
  typedef enum logic [1:0] {AX_X, AX_Y, AX_Z, AX_BAD} axis_t;
  typedef logic signed [1:0] mode_t;
  localparam int SLOTS = 6;
  localparam int NOMINAL_PLUS = 3;
  // Symmetric clamp to +/-(2^(w-1)-1) so the most-negative code of a w-bit register never appears
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a, input logic signed [31:0] b, input int w);
    logic signed [31:0] lim;
    logic signed [31:0] s;
    lim = (32'sd1 <<< (w - 1)) - 32'sd1;
    s = a + b;
    return s > lim ? lim : s < -lim ? -lim : s;
  endfunction
endpackage

// File: rtl/pipa_axis_moder.sv
// pipa_axis_moder: one PIPA axis -- signed pending count, latched ternary mode, p/m pulse registers
//   SIM_CLK/SIM_RST  clock, synchronous active-low reset
//   latch            slot 5->0 transition: pick this cycle's mode
//   enable           0 forces 3-3 at the latch
//   slot             current (pre-edge) moding slot
//   PIPDAT           AGC data strobe gating the pulse outputs
//   we/delta         command write to this axis
//   p/m              registered pulse outputs; nz = pending nonzero
module pipa_axis_moder import pipa_sched_pkg::*; #(
  parameter int PEND_W = 12,
  parameter int DELTA_W = 8
) (
  input  logic                      SIM_CLK,
  input  logic                      SIM_RST,
  input  logic                      latch,
  input  logic                      enable,
  input  logic [2:0]                slot,
  input  logic                      PIPDAT,
  input  logic                      we,
  input  logic signed [DELTA_W-1:0] delta,
  output logic                      p,
  output logic                      m,
  output logic                      nz
);
  logic signed [PEND_W-1:0] pending;
  mode_t mode, sgn, mode_d, drain;
  logic signed [31:0] sum;
  logic plus_slot;
  // Mode comes from the old pending sign; drain and command delta share one saturation
  always_comb begin
    sgn = pending > 0 ? 2'sd1 : pending < 0 ? -2'sd1 : 2'sd0;
    drain = latch && enable ? sgn : 2'sd0;
    mode_d = latch ? drain : mode;
    sum = sat_add(32'(pending) - 32'(drain), we ? 32'(delta) : 32'sd0, PEND_W);
    plus_slot = int'(slot) < NOMINAL_PLUS + int'(mode);
    nz = pending != 0;
  end
  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) begin
      pending <= '0;
      mode <= 2'sd0;
      p <= 1'b0;
      m <= 1'b0;
    end else begin
      pending <= sum[PEND_W-1:0];
      mode <= mode_d;
      p <= PIPDAT & plus_slot;
      m <= PIPDAT & ~plus_slot;
    end
  end
endmodule

// File: rtl/pipa_moding_scheduler.sv
// pipa_moding_scheduler: sequences the six PIPA pulse lines from PIPASW/PIPDAT with 3-3 ternary moding
//   SIM_CLK/SIM_RST        clock, synchronous active-low reset
//   PIPASW/PIPDAT          AGC slot strobe (rising edge advances slot) and data strobe
//   enable                 apply pending counts at the next slot-0 latch
//   cmd_valid/ready/axis/delta  velocity-increment command port, no backpressure
//   PIPA{X,Y,Z}{p,m}       pulse outputs; slot, busy, cmd_err status
module pipa_moding_scheduler import pipa_sched_pkg::*; #(
  parameter int PEND_W = 12,
  parameter int DELTA_W = 8
) (
  input  logic                      SIM_CLK,
  input  logic                      SIM_RST,
  input  logic                      PIPASW,
  input  logic                      PIPDAT,
  input  logic                      enable,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_axis,
  input  logic signed [DELTA_W-1:0] cmd_delta,
  output logic                      PIPAXp,
  output logic                      PIPAXm,
  output logic                      PIPAYp,
  output logic                      PIPAYm,
  output logic                      PIPAZp,
  output logic                      PIPAZm,
  output logic [2:0]                slot,
  output logic                      busy,
  output logic                      cmd_err
);
  logic pswd_q, sw_rise, latch, accept;
  logic [2:0] we, nz;
  always_comb begin
    sw_rise = PIPASW & ~pswd_q;
    latch = sw_rise & (slot == 3'(SLOTS - 1));
    accept = cmd_valid & cmd_ready;
    we = {accept & (cmd_axis == AX_Z), accept & (cmd_axis == AX_Y), accept & (cmd_axis == AX_X)};
  end
  always_ff @(posedge SIM_CLK) begin
    if (!SIM_RST) begin
      pswd_q <= 1'b0;
      slot <= 3'(SLOTS - 1);
      cmd_ready <= 1'b0;
      cmd_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      pswd_q <= PIPASW;
      if (sw_rise) slot <= slot == 3'(SLOTS - 1) ? 3'd0 : slot + 3'd1;
      cmd_ready <= 1'b1;
      cmd_err <= cmd_err | (accept & (cmd_axis == AX_BAD));
      busy <= |nz;
    end
  end
  pipa_axis_moder #(.PEND_W(PEND_W), .DELTA_W(DELTA_W)) u_x (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .latch(latch), .enable(enable), .slot(slot),
    .PIPDAT(PIPDAT), .we(we[0]), .delta(cmd_delta), .p(PIPAXp), .m(PIPAXm), .nz(nz[0]));
  pipa_axis_moder #(.PEND_W(PEND_W), .DELTA_W(DELTA_W)) u_y (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .latch(latch), .enable(enable), .slot(slot),
    .PIPDAT(PIPDAT), .we(we[1]), .delta(cmd_delta), .p(PIPAYp), .m(PIPAYm), .nz(nz[1]));
  pipa_axis_moder #(.PEND_W(PEND_W), .DELTA_W(DELTA_W)) u_z (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .latch(latch), .enable(enable), .slot(slot),
    .PIPDAT(PIPDAT), .we(we[2]), .delta(cmd_delta), .p(PIPAZp), .m(PIPAZm), .nz(nz[2]));
endmodule

// File: tb/tb_pipa_moding_scheduler.sv
// tb_pipa_moding_scheduler: directed self-checking bench for the PIPA moding scheduler (PEND_W=8)
module tb_pipa_moding_scheduler;
  logic SIM_CLK = 1'b0, SIM_RST = 1'b0, PIPASW = 1'b0, PIPDAT = 1'b0, enable = 1'b1, cmd_valid = 1'b0;
  logic [1:0] cmd_axis = 2'd0;
  logic signed [7:0] cmd_delta = 8'sd0;
  logic cmd_ready, PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm, busy, cmd_err;
  logic [2:0] slot;
  int total = 0, passed = 0;
  always #5 SIM_CLK = ~SIM_CLK;
  pipa_moding_scheduler #(.PEND_W(8), .DELTA_W(8)) dut (
    .SIM_CLK(SIM_CLK), .SIM_RST(SIM_RST), .PIPASW(PIPASW), .PIPDAT(PIPDAT), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_axis(cmd_axis), .cmd_delta(cmd_delta),
    .PIPAXp(PIPAXp), .PIPAXm(PIPAXm), .PIPAYp(PIPAYp), .PIPAYm(PIPAYm), .PIPAZp(PIPAZp), .PIPAZm(PIPAZm),
    .slot(slot), .busy(busy), .cmd_err(cmd_err));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  // Expected {p,m} with PIPDAT high in slot s under mode md: p for the first 3+md slots
  function automatic logic [31:0] pm(input int s, input int md);
    return (s < 3 + md) ? 32'd2 : 32'd1;
  endfunction
  task automatic step(input int s, input int mx, input int my, input int mz,
                      input logic cv, input logic [1:0] ax, input logic [7:0] d);
    @(negedge SIM_CLK);
    PIPASW = 1'b1; cmd_valid = cv; cmd_axis = ax; cmd_delta = d;
    @(negedge SIM_CLK);
    PIPASW = 1'b0; cmd_valid = 1'b0; PIPDAT = 1'b1;
    @(negedge SIM_CLK);
    PIPDAT = 1'b0;
    chk("slot", 32'(slot), 32'(s));
    chk("x_pm", {30'd0, PIPAXp, PIPAXm}, pm(s, mx));
    chk("y_pm", {30'd0, PIPAYp, PIPAYm}, pm(s, my));
    chk("z_pm", {30'd0, PIPAZp, PIPAZm}, pm(s, mz));
  endtask
  task automatic run_cycle(input int mx, input int my, input int mz,
                           input logic cv, input logic [1:0] ax, input logic [7:0] d);
    for (int s = 0; s < 6; s++) step(s, mx, my, mz, s == 0 ? cv : 1'b0, ax, d);
  endtask
  task automatic cmd(input logic [1:0] ax, input logic [7:0] d);
    @(negedge SIM_CLK);
    cmd_valid = 1'b1; cmd_axis = ax; cmd_delta = d;
    @(negedge SIM_CLK);
    cmd_valid = 1'b0;
    @(negedge SIM_CLK);
  endtask
  initial begin
    repeat (2) @(negedge SIM_CLK);
    chk("rst_slot", 32'(slot), 32'd5);
    chk("rst_outs", {26'd0, PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm}, 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(cmd_err), 32'd0);
    SIM_RST = 1'b1;
    @(negedge SIM_CLK);
    chk("ready_up", 32'(cmd_ready), 32'd1);
    // 1: idle 3-3 on every axis
    run_cycle(0, 0, 0, 1'b0, 2'd0, 8'h00);
    run_cycle(0, 0, 0, 1'b0, 2'd0, 8'h00);
    chk("t1_busy", 32'(busy), 32'd0);
    // 2: X +2 drains over two cycles
    cmd(2'd0, 8'h02);
    chk("t2_busy_set", 32'(busy), 32'd1);
    run_cycle(1, 0, 0, 1'b0, 2'd0, 8'h00);
    chk("t2_busy_mid", 32'(busy), 32'd1);
    run_cycle(1, 0, 0, 1'b0, 2'd0, 8'h00);
    chk("t2_busy_clr", 32'(busy), 32'd0);
    run_cycle(0, 0, 0, 1'b0, 2'd0, 8'h00);
    // 3: saturation at +/-127
    cmd(2'd0, 8'h7f);
    cmd(2'd0, 8'h7f);
    chk("t3_x_possat", {24'd0, dut.u_x.pending}, 32'h7f);
    cmd(2'd0, 8'h81);
    chk("t3_x_zero", {24'd0, dut.u_x.pending}, 32'h00);
    cmd(2'd2, 8'h80);
    chk("t3_z_first", {24'd0, dut.u_z.pending}, 32'h81);
    cmd(2'd2, 8'h80);
    chk("t3_z_negsat", {24'd0, dut.u_z.pending}, 32'h81);
    run_cycle(0, 0, -1, 1'b0, 2'd0, 8'h00);
    chk("t3_z_after", {24'd0, dut.u_z.pending}, 32'h82);
    cmd(2'd2, 8'h7e);
    chk("t3_z_clear", {24'd0, dut.u_z.pending}, 32'h00);
    // 4: Y +1 pending, Y +1 command on the latch cycle
    cmd(2'd1, 8'h01);
    run_cycle(0, 1, 0, 1'b1, 2'd1, 8'h01);
    chk("t4_y_pend", {24'd0, dut.u_y.pending}, 32'h01);
    chk("t4_busy", 32'(busy), 32'd1);
    cmd(2'd1, 8'hff);
    chk("t4_y_clear", {24'd0, dut.u_y.pending}, 32'h00);
    // enable=0 holds pending and forces 3-3
    cmd(2'd0, 8'h01);
    enable = 1'b0;
    run_cycle(0, 0, 0, 1'b0, 2'd0, 8'h00);
    chk("en0_x_pend", {24'd0, dut.u_x.pending}, 32'h01);
    enable = 1'b1;
    run_cycle(1, 0, 0, 1'b0, 2'd0, 8'h00);
    chk("en1_x_pend", {24'd0, dut.u_x.pending}, 32'h00);
    chk("en1_busy", 32'(busy), 32'd0);
    // 5: illegal axis
    cmd(2'd3, 8'h05);
    chk("t5_err", 32'(cmd_err), 32'd1);
    chk("t5_pend", {8'd0, dut.u_x.pending, dut.u_y.pending, dut.u_z.pending}, 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    run_cycle(0, 0, 0, 1'b0, 2'd0, 8'h00);
    chk("t5_err_sticky", 32'(cmd_err), 32'd1);
    // 6: reset during slot 2 with X pending
    cmd(2'd0, 8'h03);
    step(0, 1, 0, 0, 1'b0, 2'd0, 8'h00);
    step(1, 1, 0, 0, 1'b0, 2'd0, 8'h00);
    step(2, 1, 0, 0, 1'b0, 2'd0, 8'h00);
    @(negedge SIM_CLK);
    PIPDAT = 1'b1; SIM_RST = 1'b0;
    @(negedge SIM_CLK);
    SIM_RST = 1'b1; PIPDAT = 1'b0;
    chk("t6_outs", {26'd0, PIPAXp, PIPAXm, PIPAYp, PIPAYm, PIPAZp, PIPAZm}, 32'd0);
    chk("t6_slot", 32'(slot), 32'd5);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_err", 32'(cmd_err), 32'd0);
    chk("t6_x_pend", {24'd0, dut.u_x.pending}, 32'h00);
    run_cycle(0, 0, 0, 1'b0, 2'd0, 8'h00);
    chk("t6_busy_after", 32'(busy), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
